// File: rtl/acc_drain.sv
// Ping-pong tile accumulator: sums signed partial-sum rows into one of two banks
// and drains each finished tile to ppu as a start pulse plus ROWS row vectors.
module acc_drain #(
  parameter int LANES       = 16,
  parameter int ROWS        = 16,
  parameter int PSUM_W      = 16,
  parameter int ACC_W       = 24,
  parameter int MIN_SPACING = 48
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_psum_valid,
  input  logic [PSUM_W*LANES-1:0] i_psum_data,
  input  logic                    i_psum_first,
  input  logic                    i_psum_last,
  output logic                    o_psum_ready,
  output logic                    o_ppu_start,
  output logic [ACC_W*LANES-1:0]  o_acc_data,
  output logic                    o_busy,
  output logic [1:0]              o_dbg_state
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SP_W  = $clog2(MIN_SPACING + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]       state, state_nx;
  logic [1:0]       bank_full, bank_full_nx;
  logic             fill_ptr, drain_ptr;
  logic [ROW_W-1:0] row_cnt, drain_row;
  logic [SP_W-1:0]  sp_cnt;
  logic             tile_active;
  logic             busy_q;

  logic [ACC_W-1:0] acc_mem [2][ROWS][LANES];

  logic [ACC_W-1:0] ext_val [LANES];
  logic [ACC_W-1:0] cur_val [LANES];
  logic [ACC_W:0]   sum_val [LANES];
  logic [ACC_W-1:0] wr_val  [LANES];

  logic accept, fill_done, drain_avail, sp_expired, drain_done;

  // Handshake: a row transfers on any cycle where i_psum_valid & o_psum_ready;
  // ready depends only on registered bank state (and reset), never on valid.
  assign o_psum_ready = i_rst_n & ~bank_full[fill_ptr];
  assign accept       = i_psum_valid & o_psum_ready;
  assign fill_done    = accept & i_psum_last & (row_cnt == ROW_W'(ROWS - 1));
  // A tile completing into the drain bank this cycle may start ppu next cycle.
  assign drain_avail  = bank_full[drain_ptr] | (fill_done & (fill_ptr == drain_ptr));
  // Counter is 1 now means it reads 0 in the cycle START would occupy.
  assign sp_expired   = (sp_cnt <= SP_W'(1));
  assign drain_done   = (state == S_DATA) && (drain_row == ROW_W'(ROWS - 1));

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      ext_val[k] = {{(ACC_W-PSUM_W){i_psum_data[k*PSUM_W+PSUM_W-1]}},
                    i_psum_data[k*PSUM_W +: PSUM_W]};
      cur_val[k] = acc_mem[fill_ptr][row_cnt][k];
      sum_val[k] = {cur_val[k][ACC_W-1], cur_val[k]} + {ext_val[k][ACC_W-1], ext_val[k]};
      wr_val[k]  = sum_val[k][ACC_W-1:0];
      if (i_psum_first) begin
        wr_val[k] = ext_val[k];
      end else if (sum_val[k][ACC_W] != sum_val[k][ACC_W-1]) begin
        wr_val[k] = sum_val[k][ACC_W] ? ACC_MIN : ACC_MAX;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        acc_mem[fill_ptr][row_cnt][k] <= wr_val[k];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (drain_avail && sp_expired) state_nx = S_START;
      S_START: state_nx = S_DATA;
      S_DATA:  if (drain_done) state_nx = S_GAP;
      S_GAP:   if (sp_expired) state_nx = drain_avail ? S_START : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Fill and release always target different banks, so both can apply at once.
  always_comb begin
    bank_full_nx = bank_full;
    if (fill_done)  bank_full_nx[fill_ptr]  = 1'b1;
    if (drain_done) bank_full_nx[drain_ptr] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      bank_full   <= 2'b00;
      fill_ptr    <= 1'b0;
      drain_ptr   <= 1'b0;
      row_cnt     <= '0;
      drain_row   <= '0;
      sp_cnt      <= '0;
      tile_active <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state     <= state_nx;
      bank_full <= bank_full_nx;
      if (accept) begin
        row_cnt     <= (row_cnt == ROW_W'(ROWS - 1)) ? '0 : row_cnt + 1'b1;
        tile_active <= ~fill_done;
      end
      if (fill_done)  fill_ptr  <= ~fill_ptr;
      if (drain_done) drain_ptr <= ~drain_ptr;
      if (state == S_START) begin
        sp_cnt <= SP_W'(MIN_SPACING - 1);
      end else if (sp_cnt != '0) begin
        sp_cnt <= sp_cnt - 1'b1;
      end
      if (state == S_DATA) begin
        drain_row <= drain_done ? '0 : drain_row + 1'b1;
      end else begin
        drain_row <= '0;
      end
      busy_q <= (|bank_full) | (row_cnt != '0) | tile_active |
                (state == S_START) | (state == S_DATA);
    end
  end

  always_comb begin
    o_acc_data = '0;
    if (state == S_DATA) begin
      for (int k = 0; k < LANES; k++) begin
        o_acc_data[k*ACC_W +: ACC_W] = acc_mem[drain_ptr][drain_row][k];
      end
    end
  end

  assign o_ppu_start = (state == S_START);
  assign o_busy      = busy_q;
  assign o_dbg_state = state;

endmodule
